muldiv: RTL and testbench

MULDIV -- requirements
Module: muldiv

---
 rtl/muldiv.sv | 190 +++++++++++++++++++
 tb/tb_muldiv.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv.sv
// Iterative 32-bit multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU complete at once with zero results.
module muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        write_en,
    output logic [31:0] hi_write_data,
    output logic [31:0] lo_write_data
);

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   opb_q, opb_d;
    logic                neg_q, neg_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [2*DATA_W-1:0] step;
    logic [2*DATA_W-1:0] prod;
    logic                sgn;
`ifdef MULDIV_DIV_EN
    logic                rem_neg_q, rem_neg_d;
    logic                divz_q, divz_d;
    logic [DATA_W-1:0]   a_q, a_d;
`endif

    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic is_signed);
        return (is_signed && v[DATA_W-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [DATA_W-1:0] neg32(input logic [DATA_W-1:0] v, input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*DATA_W-1:0] neg64(input logic [2*DATA_W-1:0] v, input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

    // acc = {partial product, remaining multiplier bits}; one multiplier bit consumed per step
    function automatic logic [2*DATA_W-1:0] mul_step(input logic [2*DATA_W-1:0] acc,
                                                     input logic [DATA_W-1:0]   m);
        logic [DATA_W:0] sum;
        sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, m} : {(DATA_W+1){1'b0}});
        return {sum, acc[DATA_W-1:1]};
    endfunction

`ifdef MULDIV_DIV_EN
    // acc = {partial remainder, dividend bits / quotient bits}; the partial remainder
    // is always below the divisor, so it never needs more than DATA_W bits after a step
    function automatic logic [2*DATA_W-1:0] div_step(input logic [2*DATA_W-1:0] acc,
                                                     input logic [DATA_W-1:0]   d);
        logic [2*DATA_W:0] sh;
        logic [DATA_W+1:0] trial;
        sh    = {acc, 1'b0};
        trial = {1'b0, sh[2*DATA_W:DATA_W]} - {2'b00, d};
        if (trial[DATA_W+1])
            return sh[2*DATA_W-1:0];
        else
            return {trial[DATA_W-1:0], sh[DATA_W-1:1], 1'b1};
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        step    = '0;
        prod    = '0;
        sgn     = ~op[0];
`ifdef MULDIV_DIV_EN
        rem_neg_d = rem_neg_q;
        divz_d    = divz_q;
        a_d       = a_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    cnt_d = '0;
                    neg_d = sgn & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
                    if (!op[1]) begin
                        state_d = MUL;
                        acc_d   = {{DATA_W{1'b0}}, mag(src_b, sgn)};
                        opb_d   = mag(src_a, sgn);
                    end else begin
`ifdef MULDIV_DIV_EN
                        state_d   = DIV;
                        acc_d     = {{DATA_W{1'b0}}, mag(src_a, sgn)};
                        opb_d     = mag(src_b, sgn);
                        rem_neg_d = sgn & src_a[DATA_W-1];
                        divz_d    = (src_b == '0);
                        a_d       = src_a;
`else
                        state_d = DONE;
                        hi_d    = '0;
                        lo_d    = '0;
`endif
                    end
                end
            end
            MUL: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    step  = mul_step(acc_q, opb_q);
                    acc_d = step;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d      = DONE;
                        prod         = neg64(step, neg_q);
                        {hi_d, lo_d} = prod;
                    end
                end
            end
`ifdef MULDIV_DIV_EN
            DIV: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    step  = div_step(acc_q, opb_q);
                    acc_d = step;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = DONE;
                        if (divz_q) begin
                            hi_d = a_q;
                            lo_d = '1;
                        end else begin
                            hi_d = neg32(step[2*DATA_W-1:DATA_W], rem_neg_q);
                            lo_d = neg32(step[DATA_W-1:0], neg_q);
                        end
                    end
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MULDIV_DIV_EN
            rem_neg_q <= 1'b0;
            divz_q    <= 1'b0;
            a_q       <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MULDIV_DIV_EN
            rem_neg_q <= rem_neg_d;
            divz_q    <= divz_d;
            a_q       <= a_d;
`endif
        end
    end

    // flush must suppress the HI/LO write in the very cycle it arrives
    assign busy          = (state_q != IDLE);
    assign write_en      = (state_q == DONE) && !flush;
    assign hi_write_data = hi_q;
    assign lo_write_data = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// Scoreboard bench for muldiv: driver pushes expected results, monitor checks each write_en pulse.
module tb_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        write_en;
    logic [31:0] hi_wd;
    logic [31:0] lo_wd;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    muldiv dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .op            (op),
        .src_a         (src_a),
        .src_b         (src_b),
        .flush         (flush),
        .busy          (busy),
        .write_en      (write_en),
        .hi_write_data (hi_wd),
        .lo_write_data (lo_wd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural operand values
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint      sa, sbv, p;
        logic [63:0] u;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        h = '0;
        l = '0;
        case (o)
            2'd0: begin p = sa * sbv; h = p[63:32]; l = p[31:0]; end
            2'd1: begin u = {32'd0, a} * {32'd0, b}; h = u[63:32]; l = u[31:0]; end
            default: begin
`ifdef MULDIV_DIV_EN
                if (b == 32'd0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else if (o == 2'd2) begin
                    p = sa / sbv; l = p[31:0];
                    p = sa % sbv; h = p[31:0];
                end else begin
                    l = a / b;
                    h = a % b;
                end
`else
                h = '0;
                l = '0;
`endif
            end
        endcase
    endfunction

    function automatic int lat(input logic [1:0] o);
`ifdef MULDIV_DIV_EN
        return 32;
`else
        return o[1] ? 0 : 32;
`endif
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    // Called at posedge+1; the following edge is the acceptance edge
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input bit push);
        exp_t e;
        e.hi  = ehi;
        e.lo  = elo;
        e.cyc = cyc + 1 + lat(o);
        if (push) sb.push_back(e);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        check32("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check32("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_fixed(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] ehi, input logic [31:0] elo);
        issue(o, a, b, ehi, elo, 1'b1);
        wait_idle();
    endtask

    task automatic run_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] h, l;
        model(o, a, b, h, l);
        issue(o, a, b, h, l, 1'b1);
        wait_idle();
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && write_en === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write_en actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check32("hi_result", hi_wd, mon_e.hi);
                check32("lo_result", lo_wd, mon_e.lo);
                check32("latency_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] fop;
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'd0;
        src_a = '0;
        src_b = '0;
        #1;
        check32("reset_busy", {31'd0, busy}, 32'd0);
        check32("reset_write_en", {31'd0, write_en}, 32'd0);
        check32("reset_hi", hi_wd, 32'd0);
        check32("reset_lo", lo_wd, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        run_fixed(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_fixed(2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
`ifdef MULDIV_DIV_EN
        run_fixed(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_fixed(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_fixed(2'd3, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF);
        run_fixed(2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        fop = 2'd3;
`else
        run_fixed(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0000, 32'h0000_0000);
        run_fixed(2'd3, 32'h0000_0064, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
        fop = 2'd1;
`endif

        // Flush in cycle 10, new start accepted in cycle 11
        issue(fop, 32'h0000_1234, 32'h0000_0005, 32'd0, 32'd0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        check32("flush_write_en", {31'd0, write_en}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        check32("busy_after_flush", {31'd0, busy}, 32'd0);
        run_model(2'd0, 32'h8000_0000, 32'hFFFF_FFFF);

        // Flush arriving in DONE suppresses the pulse combinationally
        issue(2'd1, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0, 1'b0);
        repeat (32) @(posedge clk);
        #1;
        check32("done_write_en", {31'd0, write_en}, 32'd1);
        flush = 1'b1;
        #1;
        check32("done_flush_write_en", {31'd0, write_en}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        check32("busy_after_done_flush", {31'd0, busy}, 32'd0);

        // Start together with flush in IDLE is ignored
        start = 1'b1;
        flush = 1'b1;
        op    = 2'd1;
        src_a = 32'd3;
        src_b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        check32("start_with_flush_busy", {31'd0, busy}, 32'd0);

        // Start while busy is ignored; result matches the first operation
        begin
            logic [31:0] h, l;
            model(2'd0, 32'h0000_1111, 32'hFFFF_FF00, h, l);
            issue(2'd0, 32'h0000_1111, 32'hFFFF_FF00, h, l, 1'b1);
            repeat (4) @(posedge clk);
            #1;
            start = 1'b1;
            op    = 2'd1;
            src_a = 32'hDEAD_BEEF;
            src_b = 32'h0000_0003;
            @(posedge clk); #1;
            start = 1'b0;
            wait_idle();
        end

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  o;
            logic [31:0] a, b;
            o = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            run_model(o, a, b);
        end

        // Make sure the result registers hold something nonzero before the reset test
        run_model(2'd1, 32'h0001_2345, 32'h0006_789A);

        // Reset in cycle 20 of a MULT: outputs clear without a clock edge, no pulse afterwards
        issue(2'd0, 32'h0000_0033, 32'hFFFF_FFF0, 32'd0, 32'd0, 1'b0);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check32("midop_reset_busy", {31'd0, busy}, 32'd0);
        check32("midop_reset_write_en", {31'd0, write_en}, 32'd0);
        check32("midop_reset_hi", hi_wd, 32'd0);
        check32("midop_reset_lo", lo_wd, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check32("post_reset_busy", {31'd0, busy}, 32'd0);

        run_model(2'd0, 32'hFFFF_FFFF, 32'h7FFF_FFFF);

        check32("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
